lc3_reg_seq: RTL



---
 rtl/lc3_reg_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lc3_reg_seq.sv
// rtl/lc3_reg_seq.sv - LC-3 operate-instruction sequencer: RF reads, ALU handshake, write-back, NZP
module lc3_reg_seq #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_out_reg,
    input  logic [15:0] rf_outdata,
    output logic        rf_write_en,
    output logic [2:0]  rf_write_reg,
    output logic [15:0] rf_indata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_code,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] res_data,
    output logic [2:0]  nzp,
    output logic        illegal,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD1   = 3'd1;
    localparam logic [2:0] S_RD2   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;

    // Read window is RD_LAT+1 cycles; the capture happens when cnt reaches RD_LAT.
    localparam logic [1:0] CNT_LAST = 2'(RD_LAT);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  dr_q, dr_d;
    logic [2:0]  sr2_q, sr2_d;
    logic        imm_q, imm_d;
    logic [4:0]  imm5_q, imm5_d;
    logic [2:0]  rf_out_reg_q, rf_out_reg_d;
    logic        rf_write_en_q, rf_write_en_d;
    logic [2:0]  rf_write_reg_q, rf_write_reg_d;
    logic [15:0] rf_indata_q, rf_indata_d;
    logic        op_valid_q, op_valid_d;
    logic [1:0]  op_code_q, op_code_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        res_ready_q, res_ready_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        illegal_q, illegal_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dr_d           = dr_q;
        sr2_d          = sr2_q;
        imm_d          = imm_q;
        imm5_d         = imm5_q;
        rf_out_reg_d   = rf_out_reg_q;
        rf_write_en_d  = 1'b0;
        rf_write_reg_d = rf_write_reg_q;
        rf_indata_d    = rf_indata_q;
        op_valid_d     = op_valid_q;
        op_code_d      = op_code_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        res_ready_d    = res_ready_q;
        nzp_d          = nzp_q;
        illegal_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (instr[15:12] == 4'b0001 || instr[15:12] == 4'b0101 ||
                        instr[15:12] == 4'b1001) begin
                        dr_d         = instr[11:9];
                        sr2_d        = instr[2:0];
                        imm_d        = instr[5];
                        imm5_d       = instr[4:0];
                        rf_out_reg_d = instr[8:6];
                        cnt_d        = 2'd0;
                        state_d      = S_RD1;
                        case (instr[15:12])
                            4'b0001: op_code_d = OP_ADD;
                            4'b0101: op_code_d = OP_AND;
                            default: op_code_d = OP_NOT;
                        endcase
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_RD1: begin
                if (cnt_q == CNT_LAST) begin
                    op_a_d = rf_outdata;
                    cnt_d  = 2'd0;
                    if (op_code_q == OP_NOT) begin
                        op_b_d     = 16'h0000;
                        op_valid_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else if (imm_q) begin
                        op_b_d     = {{11{imm5_q[4]}}, imm5_q};
                        op_valid_d = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        rf_out_reg_d = sr2_q;
                        state_d      = S_RD2;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RD2: begin
                if (cnt_q == CNT_LAST) begin
                    op_b_d     = rf_outdata;
                    cnt_d      = 2'd0;
                    op_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    op_valid_d  = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    res_ready_d    = 1'b0;
                    rf_indata_d    = res_data;
                    rf_write_reg_d = dr_q;
                    rf_write_en_d  = 1'b1;
                    state_d        = S_WB;
                end
            end
            S_WB: begin
                if (rf_indata_q[15])
                    nzp_d = 3'b100;
                else if (rf_indata_q == 16'h0000)
                    nzp_d = 3'b010;
                else
                    nzp_d = 3'b001;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 2'd0;
            dr_q           <= 3'd0;
            sr2_q          <= 3'd0;
            imm_q          <= 1'b0;
            imm5_q         <= 5'd0;
            rf_out_reg_q   <= 3'd0;
            rf_write_en_q  <= 1'b0;
            rf_write_reg_q <= 3'd0;
            rf_indata_q    <= 16'h0000;
            op_valid_q     <= 1'b0;
            op_code_q      <= 2'b00;
            op_a_q         <= 16'h0000;
            op_b_q         <= 16'h0000;
            res_ready_q    <= 1'b0;
            nzp_q          <= 3'b010;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dr_q           <= dr_d;
            sr2_q          <= sr2_d;
            imm_q          <= imm_d;
            imm5_q         <= imm5_d;
            rf_out_reg_q   <= rf_out_reg_d;
            rf_write_en_q  <= rf_write_en_d;
            rf_write_reg_q <= rf_write_reg_d;
            rf_indata_q    <= rf_indata_d;
            op_valid_q     <= op_valid_d;
            op_code_q      <= op_code_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            res_ready_q    <= res_ready_d;
            nzp_q          <= nzp_d;
            illegal_q      <= illegal_d;
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign rf_out_reg   = rf_out_reg_q;
    assign rf_write_en  = rf_write_en_q;
    assign rf_write_reg = rf_write_reg_q;
    assign rf_indata    = rf_indata_q;
    assign op_valid     = op_valid_q;
    assign op_code      = op_code_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign res_ready    = res_ready_q;
    assign nzp          = nzp_q;
    assign illegal      = illegal_q;

endmodule
